// File: rtl/crc8_check.sv
// ============================================================================
// Module   : crc8_check
// Purpose  : Receive-side CRC-8 frame checker for a 64b/66b block stream.
//            Passes blocks through with one cycle of latency.
// Option   : CRC8_CHECK_STRIP_EN zeroes the CRC byte of forwarded TERM blocks.
// Revision : 1.0
// ============================================================================
`default_nettype none

module crc8_check #(
  parameter logic [7:0] POLY       = 8'h07,
  parameter logic [7:0] INIT       = 8'h00,
  parameter logic [7:0] START_TYPE = 8'h78,
  parameter logic [7:0] TERM_TYPE  = 8'hFF,
  parameter int         ERR_CNT_W  = 16
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 valid_in,
  input  logic [1:0]           header_in,
  input  logic [63:0]          payload_in,
  output logic                 valid_out,
  output logic [1:0]           header_out,
  output logic [63:0]          payload_out,
  output logic                 crc_ok_out,
  output logic                 crc_err_out,
  output logic                 frame_err_out,
  output logic                 in_frame_out,
  output logic [ERR_CNT_W-1:0] err_count_out
);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  localparam logic [ERR_CNT_W-1:0] C_CNT_ONE = {{(ERR_CNT_W-1){1'b0}}, 1'b1};

  state_t                state_q, state_d;
  logic [7:0]            crc_q, crc_d;
  logic                  valid_q, valid_d;
  logic [1:0]            header_q, header_d;
  logic [63:0]           payload_q, payload_d;
  logic                  ok_q, ok_d;
  logic                  err_q, err_d;
  logic                  ferr_q, ferr_d;
  logic [ERR_CNT_W-1:0]  cnt_q, cnt_d;

  logic                  w_is_data;
  logic                  w_is_ctrl;
  logic                  w_bad_hdr;
  logic                  w_is_start;
  logic                  w_is_term;
  logic [7:0]            w_crc_next;

  // Serial MSB-first CRC unrolled over one 64-bit block
  function automatic logic [7:0] crc_step(input logic [7:0] crc_in, input logic [63:0] data);
    logic [7:0] c;
    logic       fb;
    c = crc_in;
    for (int i = 63; i >= 0; i--) begin
      fb = c[7] ^ data[i];
      c  = {c[6:0], 1'b0} ^ (fb ? POLY : 8'h00);
    end
    return c;
  endfunction

  assign w_is_data  = valid_in && (header_in == 2'b01);
  assign w_is_ctrl  = valid_in && (header_in == 2'b10);
  assign w_bad_hdr  = valid_in && ((header_in == 2'b00) || (header_in == 2'b11));
  assign w_is_start = w_is_ctrl && (payload_in[7:0] == START_TYPE);
  assign w_is_term  = w_is_ctrl && (payload_in[7:0] == TERM_TYPE);
  assign w_crc_next = crc_step(crc_q, payload_in);

  always_comb begin
    state_d = state_q;
    crc_d   = crc_q;
    ok_d    = 1'b0;
    err_d   = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (w_is_start) begin
          crc_d   = INIT;
          state_d = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        if (w_is_data) begin
          crc_d = w_crc_next;
        end else if (w_is_term) begin
          if (crc_q == payload_in[15:8]) ok_d = 1'b1;
          else                            err_d = 1'b1;
          state_d = ST_IDLE;
        end else if (w_is_start) begin
          ferr_d = 1'b1;
          crc_d  = INIT;
        end else if (w_bad_hdr) begin
          ferr_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if ((err_d || ferr_d) && (cnt_q != {ERR_CNT_W{1'b1}})) begin
      cnt_d = cnt_q + C_CNT_ONE;
    end
  end

  always_comb begin
    valid_d   = valid_in;
    header_d  = header_in;
    payload_d = payload_in;
`ifdef CRC8_CHECK_STRIP_EN
    if ((state_q == ST_ACTIVE) && w_is_term) begin
      payload_d[15:8] = 8'h00;
    end
`endif
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q   <= ST_IDLE;
      crc_q     <= INIT;
      valid_q   <= 1'b0;
      header_q  <= 2'b00;
      payload_q <= 64'h0;
      ok_q      <= 1'b0;
      err_q     <= 1'b0;
      ferr_q    <= 1'b0;
      cnt_q     <= {ERR_CNT_W{1'b0}};
    end else begin
      state_q   <= state_d;
      crc_q     <= crc_d;
      valid_q   <= valid_d;
      header_q  <= header_d;
      payload_q <= payload_d;
      ok_q      <= ok_d;
      err_q     <= err_d;
      ferr_q    <= ferr_d;
      cnt_q     <= cnt_d;
    end
  end

  assign valid_out     = valid_q;
  assign header_out    = header_q;
  assign payload_out   = payload_q;
  assign crc_ok_out    = ok_q;
  assign crc_err_out   = err_q;
  assign frame_err_out = ferr_q;
  assign in_frame_out  = (state_q == ST_ACTIVE);
  assign err_count_out = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_crc8_check.sv
// ============================================================================
// Module   : tb_crc8_check
// Purpose  : Directed self-checking bench for crc8_check (default and
//            2-bit error counter instances share one stimulus stream).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_crc8_check;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        valid_in = 1'b0;
  logic [1:0]  header_in = 2'b00;
  logic [63:0] payload_in = 64'h0;

  logic        valid_out, crc_ok_out, crc_err_out, frame_err_out, in_frame_out;
  logic [1:0]  header_out;
  logic [63:0] payload_out;
  logic [15:0] err_count_out;

  logic        s_valid, s_ok, s_err, s_ferr, s_in_frame;
  logic [1:0]  s_header;
  logic [63:0] s_payload;
  logic [1:0]  s_count;

  int total = 0;
  int bad   = 0;

  localparam logic [1:0] H_DATA = 2'b01;
  localparam logic [1:0] H_CTRL = 2'b10;

  always #5 clk_in = ~clk_in;

  crc8_check u_dut (
    .clk_in(clk_in), .rst_in(rst_in), .valid_in(valid_in), .header_in(header_in),
    .payload_in(payload_in), .valid_out(valid_out), .header_out(header_out),
    .payload_out(payload_out), .crc_ok_out(crc_ok_out), .crc_err_out(crc_err_out),
    .frame_err_out(frame_err_out), .in_frame_out(in_frame_out), .err_count_out(err_count_out)
  );

  crc8_check #(.ERR_CNT_W(2)) u_sat (
    .clk_in(clk_in), .rst_in(rst_in), .valid_in(valid_in), .header_in(header_in),
    .payload_in(payload_in), .valid_out(s_valid), .header_out(s_header),
    .payload_out(s_payload), .crc_ok_out(s_ok), .crc_err_out(s_err),
    .frame_err_out(s_ferr), .in_frame_out(s_in_frame), .err_count_out(s_count)
  );

  function automatic logic [63:0] ctrl(input logic [7:0] typ, input logic [7:0] crc);
    return {48'h0123_4567_89AB, crc, typ};
  endfunction

  // One block per call; returns 1 ns after the capturing edge
  task automatic send(input logic v, input logic [1:0] h, input logic [63:0] p);
    @(negedge clk_in);
    valid_in   = v;
    header_in  = h;
    payload_in = p;
    @(posedge clk_in);
    #1;
    valid_in = 1'b0;
  endtask

  task automatic gap();
    @(negedge clk_in);
    valid_in = 1'b0;
    @(posedge clk_in);
    #1;
  endtask

  task automatic test_reset();
    #12;
    total++;
    if ({valid_out, header_out, payload_out, crc_ok_out, crc_err_out, frame_err_out,
         in_frame_out, err_count_out} !== 87'h0) begin
      bad++;
      $display("FAIL reset_main: got v=%b h=%b p=%h ok=%b err=%b ferr=%b in=%b cnt=%0d, want all 0",
               valid_out, header_out, payload_out, crc_ok_out, crc_err_out, frame_err_out,
               in_frame_out, err_count_out);
    end
    total++;
    if ({s_valid, s_ok, s_err, s_ferr, s_in_frame, s_count} !== 7'h0) begin
      bad++;
      $display("FAIL reset_sat: got %b want 0", {s_valid, s_ok, s_err, s_ferr, s_in_frame, s_count});
    end
    @(negedge clk_in);
    rst_in = 1'b0;
  endtask

  task automatic test_ok_zero();
    send(1'b1, H_CTRL, ctrl(8'h78, 8'h00));
    total++;
    if ({in_frame_out, valid_out, header_out} !== 4'b1110) begin
      bad++;
      $display("FAIL start_enter: in/v/h=%b want 1110", {in_frame_out, valid_out, header_out});
    end
    send(1'b1, H_DATA, 64'h0);
    send(1'b1, H_CTRL, ctrl(8'hFF, 8'h00));
    total++;
    if ({crc_ok_out, crc_err_out, frame_err_out, err_count_out} !== {3'b100, 16'd0}) begin
      bad++;
      $display("FAIL ok_zero: pulses=%b cnt=%0d want 100 cnt=0",
               {crc_ok_out, crc_err_out, frame_err_out}, err_count_out);
    end
    gap();
    total++;
    if ({crc_ok_out, valid_out, in_frame_out} !== 3'b000) begin
      bad++;
      $display("FAIL ok_zero_single_cycle: ok/v/in=%b want 000", {crc_ok_out, valid_out, in_frame_out});
    end
  endtask

  task automatic test_ok_one();
    logic [63:0] exp_p;
    send(1'b1, H_CTRL, ctrl(8'h78, 8'h00));
    send(1'b1, H_DATA, 64'h1);
    send(1'b1, H_CTRL, ctrl(8'hFF, 8'h07));
    total++;
    if ({crc_ok_out, crc_err_out, frame_err_out, valid_out} !== 4'b1001) begin
      bad++;
      $display("FAIL ok_one: ok/err/ferr/v=%b want 1001",
               {crc_ok_out, crc_err_out, frame_err_out, valid_out});
    end
    exp_p = ctrl(8'hFF, 8'h07);
`ifdef CRC8_CHECK_STRIP_EN
    exp_p[15:8] = 8'h00;
`endif
    total++;
    if ({header_out, payload_out} !== {H_CTRL, exp_p}) begin
      bad++;
      $display("FAIL term_passthru: h=%b p=%h want h=10 p=%h", header_out, payload_out, exp_p);
    end
  endtask

  task automatic test_crc_err();
    send(1'b1, H_CTRL, ctrl(8'h78, 8'h00));
    send(1'b1, H_DATA, 64'h1);
    send(1'b1, H_CTRL, ctrl(8'hFF, 8'h08));
    total++;
    if ({crc_ok_out, crc_err_out, frame_err_out, err_count_out} !== {3'b010, 16'd1}) begin
      bad++;
      $display("FAIL crc_err: pulses=%b cnt=%0d want 010 cnt=1",
               {crc_ok_out, crc_err_out, frame_err_out}, err_count_out);
    end
    gap();
    total++;
    if ({crc_ok_out, crc_err_out, frame_err_out, in_frame_out} !== 4'b0000) begin
      bad++;
      $display("FAIL crc_err_after: %b want 0000",
               {crc_ok_out, crc_err_out, frame_err_out, in_frame_out});
    end
  endtask

  task automatic test_restart();
    send(1'b1, H_CTRL, ctrl(8'h78, 8'h00));
    send(1'b1, H_DATA, 64'h1);
    send(1'b1, H_CTRL, ctrl(8'h78, 8'h00));
    total++;
    if ({crc_ok_out, crc_err_out, frame_err_out, in_frame_out, err_count_out} !== {4'b0011, 16'd2}) begin
      bad++;
      $display("FAIL restart_ferr: pulses/in=%b cnt=%0d want 0011 cnt=2",
               {crc_ok_out, crc_err_out, frame_err_out, in_frame_out}, err_count_out);
    end
    send(1'b1, H_DATA, 64'h0);
    send(1'b1, H_CTRL, ctrl(8'hFF, 8'h00));
    total++;
    if ({crc_ok_out, crc_err_out, frame_err_out, err_count_out} !== {3'b100, 16'd2}) begin
      bad++;
      $display("FAIL restart_ok: pulses=%b cnt=%0d want 100 cnt=2",
               {crc_ok_out, crc_err_out, frame_err_out}, err_count_out);
    end
  endtask

  task automatic test_other_ctrl();
    send(1'b1, H_CTRL, ctrl(8'h78, 8'h00));
    send(1'b1, H_DATA, 64'h1);
    send(1'b1, H_CTRL, ctrl(8'h1E, 8'h55));
    total++;
    if ({crc_ok_out, crc_err_out, frame_err_out, in_frame_out, valid_out} !== 5'b00011) begin
      bad++;
      $display("FAIL other_ctrl_pass: %b want 00011",
               {crc_ok_out, crc_err_out, frame_err_out, in_frame_out, valid_out});
    end
    send(1'b1, H_CTRL, ctrl(8'hFF, 8'h07));
    total++;
    if ({crc_ok_out, crc_err_out, frame_err_out} !== 3'b100) begin
      bad++;
      $display("FAIL other_ctrl_crc: pulses=%b want 100", {crc_ok_out, crc_err_out, frame_err_out});
    end
  endtask

  task automatic test_gaps();
    // 64'h80 -> 8'h89 ; 64'h0 then 64'h81 -> 8'h8E ; 64'h100 -> 8'h15
    send(1'b1, H_CTRL, ctrl(8'h78, 8'h00));
    gap();
    send(1'b1, H_DATA, 64'h80);
    gap();
    gap();
    total++;
    if ({valid_out, in_frame_out} !== 2'b01) begin
      bad++;
      $display("FAIL gap_valid: v/in=%b want 01", {valid_out, in_frame_out});
    end
    send(1'b1, H_CTRL, ctrl(8'hFF, 8'h89));
    total++;
    if ({crc_ok_out, crc_err_out} !== 2'b10) begin
      bad++;
      $display("FAIL gap_crc89: ok/err=%b want 10", {crc_ok_out, crc_err_out});
    end
    send(1'b1, H_CTRL, ctrl(8'h78, 8'h00));
    send(1'b1, H_DATA, 64'h0);
    gap();
    send(1'b1, H_DATA, 64'h81);
    send(1'b1, H_CTRL, ctrl(8'hFF, 8'h8E));
    total++;
    if ({crc_ok_out, crc_err_out} !== 2'b10) begin
      bad++;
      $display("FAIL two_block_crc8e: ok/err=%b want 10", {crc_ok_out, crc_err_out});
    end
    send(1'b1, H_CTRL, ctrl(8'h78, 8'h00));
    send(1'b1, H_DATA, 64'h100);
    send(1'b1, H_CTRL, ctrl(8'hFF, 8'h15));
    total++;
    if ({crc_ok_out, crc_err_out, err_count_out} !== {2'b10, 16'd2}) begin
      bad++;
      $display("FAIL crc15: ok/err=%b cnt=%0d want 10 cnt=2", {crc_ok_out, crc_err_out}, err_count_out);
    end
  endtask

  task automatic test_bad_header();
    send(1'b1, H_CTRL, ctrl(8'h78, 8'h00));
    send(1'b1, H_DATA, 64'h1);
    send(1'b1, 2'b00, 64'h1234);
    total++;
    if ({frame_err_out, in_frame_out, err_count_out} !== {2'b10, 16'd3}) begin
      bad++;
      $display("FAIL bad_hdr00: ferr/in=%b cnt=%0d want 10 cnt=3", {frame_err_out, in_frame_out}, err_count_out);
    end
    send(1'b1, H_CTRL, ctrl(8'hFF, 8'h00));
    total++;
    if ({crc_ok_out, crc_err_out, frame_err_out, in_frame_out} !== 4'b0000) begin
      bad++;
      $display("FAIL term_after_abort: %b want 0000",
               {crc_ok_out, crc_err_out, frame_err_out, in_frame_out});
    end
    send(1'b1, H_CTRL, ctrl(8'h78, 8'h00));
    send(1'b1, 2'b11, 64'h0);
    total++;
    if ({frame_err_out, in_frame_out, err_count_out} !== {2'b10, 16'd4}) begin
      bad++;
      $display("FAIL bad_hdr11: ferr/in=%b cnt=%0d want 10 cnt=4", {frame_err_out, in_frame_out}, err_count_out);
    end
  endtask

  task automatic test_idle_ignore();
    send(1'b1, H_DATA, 64'h1);
    send(1'b1, 2'b00, 64'h0);
    send(1'b1, H_CTRL, ctrl(8'hFF, 8'h08));
    total++;
    if ({crc_ok_out, crc_err_out, frame_err_out, in_frame_out, err_count_out} !== {4'b0000, 16'd4}) begin
      bad++;
      $display("FAIL idle_ignore: %b cnt=%0d want 0000 cnt=4",
               {crc_ok_out, crc_err_out, frame_err_out, in_frame_out}, err_count_out);
    end
    send(1'b0, H_CTRL, ctrl(8'h78, 8'h00));
    total++;
    if ({valid_out, in_frame_out} !== 2'b00) begin
      bad++;
      $display("FAIL invalid_start: v/in=%b want 00", {valid_out, in_frame_out});
    end
  endtask

  task automatic test_saturate();
    logic [1:0] exp_s;
    @(negedge clk_in);
    rst_in = 1'b1;
    @(negedge clk_in);
    rst_in = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      send(1'b1, H_CTRL, ctrl(8'h78, 8'h00));
      send(1'b1, H_DATA, 64'h1);
      send(1'b1, H_CTRL, ctrl(8'hFF, 8'h08));
      exp_s = (k > 3) ? 2'd3 : 2'(k);
      total++;
      if ({s_err, s_count, err_count_out} !== {1'b1, exp_s, 16'(k)}) begin
        bad++;
        $display("FAIL saturate_%0d: sat_err=%b sat_cnt=%0d cnt=%0d want 1 %0d %0d",
                 k, s_err, s_count, err_count_out, exp_s, k);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    send(1'b1, H_CTRL, ctrl(8'h78, 8'h00));
    send(1'b1, H_DATA, 64'h1);
    @(negedge clk_in);
    rst_in = 1'b1;
    #1;
    total++;
    if ({in_frame_out, valid_out, err_count_out} !== 18'h0) begin
      bad++;
      $display("FAIL async_reset: in/v=%b cnt=%0d want 00 cnt=0", {in_frame_out, valid_out}, err_count_out);
    end
    @(negedge clk_in);
    rst_in = 1'b0;
    send(1'b1, H_CTRL, ctrl(8'hFF, 8'h07));
    total++;
    if ({crc_ok_out, crc_err_out, frame_err_out, in_frame_out, err_count_out} !== {4'b0000, 16'd0}) begin
      bad++;
      $display("FAIL term_after_reset: %b cnt=%0d want 0000 cnt=0",
               {crc_ok_out, crc_err_out, frame_err_out, in_frame_out}, err_count_out);
    end
  endtask

  initial begin
    test_reset();
    test_ok_zero();
    test_ok_one();
    test_crc_err();
    test_restart();
    test_other_ctrl();
    test_gaps();
    test_bad_header();
    test_idle_ignore();
    test_saturate();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
